frame_demapper: RTL and testbench
=================================

# frame_demapper

Parametrised receive-side demapper. It recovers frame alignment from the FAS marker and tracks row/column position internally. It extracts the ARQ and CRC overhead bytes, checks a byte-serial CRC-8 over each frame's payload, and delivers payload bytes to the client FIFO only while aligned. It sits between the serial receiver (line side) and the tx AXIS FIFO (client side). It replaces the fixed-geometry demapper with configurable frame geometry, an alignment state machine with hysteresis, and error accounting.

## Interface
- ROWS, 4, rows per frame (>= 2)
- COLS, 1040, columns per row (bytes, > OH_COLS)
- OH_COLS, 16, leading overhead columns per row (>= 2)
- CRC_POLY, 8'h07, CRC-8 polynomial; MSB-first, init 8'h00, no reflection, no final XOR
- SYNC_CNT, 2, consecutive good FAS required to enter SYNC (>= 1)
- LOSS_CNT, 3, consecutive missed FAS required to drop SYNC (>= 1)

Ports:
- i_clk  in  1  clock
- i_rst_n  in  1  asynchronous, active-low reset
- i_frame_data  in  8  line byte
- i_frame_data_valid  in  1  beat qualifier; position advances only on valid beats
- i_frame_data_fas  in  1  FAS marker, meaningful only with valid
- o_pyld_data  out  8  payload byte
- o_pyld_data_valid  out  1  payload strobe
- o_pyld_sof  out  1  first payload byte of a frame (with valid)
- o_arq_en  out  1  bit 0 of the ARQ overhead byte
- o_arq_en_valid  out  1  one-cycle strobe
- o_crc_err  out  1  CRC mismatch for the previous frame
- o_crc_err_valid  out  1  one-cycle strobe
- o_crc_val  out  8  CRC calculated over the last completed frame
- o_sync  out  1  high in SYNC
- o_crc_err_cnt  out  16  saturating mismatch count

## Operation
- Frame layout: row-major, ROWS×COLS bytes.
  - Row 0 col 0 is FAS.
  - Row 0 col 1 is ARQ.
  - Row 1 col 0 is the CRC byte.
  - Other columns < OH_COLS are reserved and are discarded.
  - Columns >= OH_COLS are payload, giving ROWS×(COLS−OH_COLS) payload bytes per frame.
- Position counter: row is $clog2(ROWS) bits and col is $clog2(COLS) bits. Col wraps COLS−1→0 and increments row; row wraps ROWS−1→0.
- FSM states: HUNT, PRESYNC, SYNC.
  - HUNT: position ignored. A valid beat with FAS=1 loads position to (0,0), good count=1, and goes to PRESYNC. If SYNC_CNT=1, it goes to SYNC directly.
  - PRESYNC: at each expected (0,0) beat, FAS=1 increments the good count; reaching SYNC_CNT goes to SYNC. FAS=0 at (0,0), or FAS=1 at any other position, goes to HUNT.
  - SYNC: at each expected (0,0) beat, FAS=0 increments the miss count; FAS=1 clears it. Miss count reaching LOSS_CNT goes to HUNT. FAS=1 at a non-(0,0) position is counted as a miss and does not realign.
- Payload, ARQ and CRC outputs are produced only in SYNC. A byte at (0,0) in HUNT that causes the transition is not output.
- CRC: accumulated over payload bytes of the current frame. At the last payload byte, i.e. position (ROWS−1, COLS−1):
  - the result latches to o_crc_val;
  - the accumulator reinitialises to 00.
- The CRC byte of frame N is compared with the latched CRC of frame N−1.
  - The compare is suppressed (no strobe) until one full frame has been accumulated in SYNC since last entering SYNC.
  - Mismatch sets o_crc_err=1 and increments o_crc_err_cnt, which saturates at 16'hFFFF.
- Leaving SYNC: the accumulator resets and the "previous frame valid" flag clears.
- Reset: all outputs 0, FSM to HUNT, counters and CRC cleared. This applies at any time, including mid-frame.

## Timing
- All outputs are registered, with one-cycle latency from the qualifying input beat.
- o_crc_err and o_arq_en hold their last value between strobes. Strobes last exactly one cycle.
- No backpressure: the client must accept every o_pyld_data_valid beat.
- Gaps with valid=0 are allowed anywhere; state and position hold.
- o_sync rises in the cycle after the SYNC_CNT-th good FAS beat and falls in the cycle after the LOSS_CNT-th miss.

## Structure
- demap_pkg: FSM state enum, overhead position constants (FAS, ARQ, CRC row/col), and a crc8_step function parameterised by polynomial.
- Sub-module frame_align_fsm: HUNT/PRESYNC/SYNC states, good/miss counters, position counter. Outputs in_sync, row, col.
- frame_demapper holds the payload/overhead decode, CRC accumulator/compare and error counter.

## Test plan
- Use ROWS=2, COLS=8, OH_COLS=2, SYNC_CNT=2, LOSS_CNT=3 (12 payload bytes/frame) for all scenarios.
- Clean stream: 4 frames, payload 0x00..0x0B, ARQ byte 0x01, correct CRCs.
  - o_sync rises after frame 2 FAS.
  - 12 payload beats/frame with sof on byte 0x00.
  - o_arq_en=1 strobes.
  - No o_crc_err.
  - o_crc_val matches the model.
- Corrupt one payload byte of frame 3: the CRC strobe during frame 4 has o_crc_err=1, and o_crc_err_cnt goes 0→1.
- Spurious FAS=1 at row 1 col 3 during PRESYNC: returns to HUNT, no payload output, o_sync stays 0.
- In SYNC, drop FAS for 2 frames then restore: o_sync stays 1. Drop for 3 frames: o_sync falls one cycle after the third miss, and payload stops.
- Random valid=0 gaps (50%) over 3 frames: output payload sequence and CRC results are identical to the gap-free run.
- Assert i_rst_n low mid-payload in SYNC: all outputs 0 immediately. After release, the first CRC strobe appears only after one full frame accumulated in SYNC.

Source files
------------

// File: rtl/frame_demapper_pkg.sv
`default_nettype none
// ============================================================================
// Module      : demap_pkg
// Description : Shared types, overhead positions and CRC-8 step for the
//               receive-side frame demapper.
// Revision    : 1.0 - initial release
// ============================================================================
package demap_pkg;

    typedef enum logic [1:0] {
        ST_HUNT    = 2'd0,
        ST_PRESYNC = 2'd1,
        ST_SYNC    = 2'd2
    } align_state_t;

    localparam int c_FAS_ROW = 0;
    localparam int c_FAS_COL = 0;
    localparam int c_ARQ_ROW = 0;
    localparam int c_ARQ_COL = 1;
    localparam int c_CRC_ROW = 1;
    localparam int c_CRC_COL = 0;

    // One byte through an MSB-first CRC-8 with no reflection.
    function automatic logic [7:0] crc8_step(
        input logic [7:0] crc,
        input logic [7:0] data,
        input logic [7:0] poly
    );
        logic [7:0] r;
        r = crc ^ data;
        for (int i = 0; i < 8; i++) begin
            r = r[7] ? ((r << 1) ^ poly) : (r << 1);
        end
        return r;
    endfunction

endpackage
`default_nettype wire

// File: rtl/frame_demapper_align_fsm.sv
`default_nettype none
// ============================================================================
// Module      : frame_align_fsm
// Description : FAS-driven HUNT/PRESYNC/SYNC alignment with hysteresis and
//               the row/column position of the next expected line byte.
// Revision    : 1.0 - initial release
// ============================================================================
module frame_align_fsm
    import demap_pkg::*;
#(
    parameter int ROWS     = 4,
    parameter int COLS     = 1040,
    parameter int SYNC_CNT = 2,
    parameter int LOSS_CNT = 3,
    parameter int ROW_W    = $clog2(ROWS),
    parameter int COL_W    = $clog2(COLS)
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_valid,
    input  logic             i_fas,
    output logic             o_in_sync,
    output logic [ROW_W-1:0] o_row,
    output logic [COL_W-1:0] o_col
);

    localparam int c_GOOD_W = $clog2(SYNC_CNT + 1);
    localparam int c_MISS_W = $clog2(LOSS_CNT + 1);
    localparam logic [ROW_W-1:0]    c_ROW_LAST = ROW_W'(ROWS - 1);
    localparam logic [COL_W-1:0]    c_COL_LAST = COL_W'(COLS - 1);
    localparam logic [c_GOOD_W-1:0] c_GOOD_TGT = c_GOOD_W'(SYNC_CNT - 1);
    localparam logic [c_MISS_W-1:0] c_MISS_TGT = c_MISS_W'(LOSS_CNT - 1);

    align_state_t        r_state;
    logic [c_GOOD_W-1:0] r_good;
    logic [c_MISS_W-1:0] r_miss;
    logic [ROW_W-1:0]    r_row;
    logic [COL_W-1:0]    r_col;

    logic             w_at_origin;
    logic             w_col_last;
    logic [ROW_W-1:0] w_row_nxt;
    logic [COL_W-1:0] w_col_nxt;

    assign w_at_origin = (r_row == ROW_W'(c_FAS_ROW)) && (r_col == COL_W'(c_FAS_COL));
    assign w_col_last  = (r_col == c_COL_LAST);
    assign w_col_nxt   = w_col_last ? '0 : r_col + 1'b1;
    assign w_row_nxt   = !w_col_last ? r_row : ((r_row == c_ROW_LAST) ? '0 : r_row + 1'b1);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= ST_HUNT;
            r_good  <= '0;
            r_miss  <= '0;
            r_row   <= '0;
            r_col   <= '0;
        end else if (i_valid) begin
            case (r_state)
                ST_HUNT: begin
                    // The FAS beat itself sits at (0,0); the next beat is (0,1).
                    if (i_fas) begin
                        r_row   <= '0;
                        r_col   <= COL_W'(1);
                        r_good  <= c_GOOD_W'(1);
                        r_miss  <= '0;
                        r_state <= (SYNC_CNT == 1) ? ST_SYNC : ST_PRESYNC;
                    end
                end
                ST_PRESYNC: begin
                    r_row <= w_row_nxt;
                    r_col <= w_col_nxt;
                    if (w_at_origin && i_fas) begin
                        r_good <= r_good + 1'b1;
                        if (r_good == c_GOOD_TGT) begin
                            r_state <= ST_SYNC;
                            r_miss  <= '0;
                        end
                    end else if (w_at_origin || i_fas) begin
                        r_state <= ST_HUNT;
                    end
                end
                ST_SYNC: begin
                    r_row <= w_row_nxt;
                    r_col <= w_col_nxt;
                    // Missing FAS at (0,0) and stray FAS elsewhere both count as misses.
                    if (w_at_origin && i_fas) begin
                        r_miss <= '0;
                    end else if (w_at_origin || i_fas) begin
                        if (r_miss == c_MISS_TGT) begin
                            r_state <= ST_HUNT;
                            r_miss  <= '0;
                        end else begin
                            r_miss <= r_miss + 1'b1;
                        end
                    end
                end
                default: r_state <= ST_HUNT;
            endcase
        end
    end

    assign o_in_sync = (r_state == ST_SYNC);
    assign o_row     = r_row;
    assign o_col     = r_col;

endmodule
`default_nettype wire

// File: rtl/frame_demapper.sv
`default_nettype none
// ============================================================================
// Module      : frame_demapper
// Description : Receive-side demapper: payload extraction, ARQ/CRC overhead
//               decode, per-frame CRC-8 check and error accounting.
// Revision    : 1.0 - initial release
// ============================================================================
module frame_demapper
    import demap_pkg::*;
#(
    parameter int         ROWS     = 4,
    parameter int         COLS     = 1040,
    parameter int         OH_COLS  = 16,
    parameter logic [7:0] CRC_POLY = 8'h07,
    parameter int         SYNC_CNT = 2,
    parameter int         LOSS_CNT = 3
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic [7:0]  i_frame_data,
    input  logic        i_frame_data_valid,
    input  logic        i_frame_data_fas,
    output logic [7:0]  o_pyld_data,
    output logic        o_pyld_data_valid,
    output logic        o_pyld_sof,
    output logic        o_arq_en,
    output logic        o_arq_en_valid,
    output logic        o_crc_err,
    output logic        o_crc_err_valid,
    output logic [7:0]  o_crc_val,
    output logic        o_sync,
    output logic [15:0] o_crc_err_cnt
);

    localparam int c_ROW_W = $clog2(ROWS);
    localparam int c_COL_W = $clog2(COLS);
    localparam logic [c_ROW_W-1:0] c_ROW_LAST = c_ROW_W'(ROWS - 1);
    localparam logic [c_COL_W-1:0] c_COL_LAST = c_COL_W'(COLS - 1);

    logic               w_in_sync;
    logic [c_ROW_W-1:0] w_row;
    logic [c_COL_W-1:0] w_col;

    frame_align_fsm #(
        .ROWS     (ROWS),
        .COLS     (COLS),
        .SYNC_CNT (SYNC_CNT),
        .LOSS_CNT (LOSS_CNT),
        .ROW_W    (c_ROW_W),
        .COL_W    (c_COL_W)
    ) u_align (
        .i_clk     (i_clk),
        .i_rst_n   (i_rst_n),
        .i_valid   (i_frame_data_valid),
        .i_fas     (i_frame_data_fas),
        .o_in_sync (w_in_sync),
        .o_row     (w_row),
        .o_col     (w_col)
    );

    logic [7:0]  r_pyld_data;
    logic        r_pyld_valid;
    logic        r_pyld_sof;
    logic        r_arq_en;
    logic        r_arq_valid;
    logic        r_crc_err;
    logic        r_crc_err_valid;
    logic [7:0]  r_crc_val;
    logic [7:0]  r_crc_acc;
    logic        r_prev_ok;
    logic [15:0] r_err_cnt;

    logic       w_is_pyld;
    logic       w_is_first;
    logic       w_is_last;
    logic       w_is_arq;
    logic       w_is_crc;
    logic       w_crc_mismatch;
    logic [7:0] w_crc_next;

    assign w_is_pyld      = (w_col >= c_COL_W'(OH_COLS));
    assign w_is_first     = (w_row == '0) && (w_col == c_COL_W'(OH_COLS));
    assign w_is_last      = (w_row == c_ROW_LAST) && (w_col == c_COL_LAST);
    assign w_is_arq       = (w_row == c_ROW_W'(c_ARQ_ROW)) && (w_col == c_COL_W'(c_ARQ_COL));
    assign w_is_crc       = (w_row == c_ROW_W'(c_CRC_ROW)) && (w_col == c_COL_W'(c_CRC_COL));
    assign w_crc_next     = crc8_step(r_crc_acc, i_frame_data, CRC_POLY);
    assign w_crc_mismatch = (i_frame_data != r_crc_val);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_pyld_data     <= '0;
            r_pyld_valid    <= 1'b0;
            r_pyld_sof      <= 1'b0;
            r_arq_en        <= 1'b0;
            r_arq_valid     <= 1'b0;
            r_crc_err       <= 1'b0;
            r_crc_err_valid <= 1'b0;
            r_crc_val       <= '0;
            r_crc_acc       <= '0;
            r_prev_ok       <= 1'b0;
            r_err_cnt       <= '0;
        end else begin
            r_pyld_valid    <= 1'b0;
            r_pyld_sof      <= 1'b0;
            r_arq_valid     <= 1'b0;
            r_crc_err_valid <= 1'b0;
            if (!w_in_sync) begin
                // Out of SYNC nothing accumulates and the previous-frame CRC is stale.
                r_crc_acc <= '0;
                r_prev_ok <= 1'b0;
            end else if (i_frame_data_valid) begin
                if (w_is_pyld) begin
                    r_pyld_data  <= i_frame_data;
                    r_pyld_valid <= 1'b1;
                    r_pyld_sof   <= w_is_first;
                    if (w_is_last) begin
                        r_crc_val <= w_crc_next;
                        r_crc_acc <= '0;
                        r_prev_ok <= 1'b1;
                    end else begin
                        r_crc_acc <= w_crc_next;
                    end
                end
                if (w_is_arq) begin
                    r_arq_en    <= i_frame_data[0];
                    r_arq_valid <= 1'b1;
                end
                if (w_is_crc && r_prev_ok) begin
                    r_crc_err_valid <= 1'b1;
                    r_crc_err       <= w_crc_mismatch;
                    if (w_crc_mismatch && (r_err_cnt != 16'hFFFF)) begin
                        r_err_cnt <= r_err_cnt + 16'd1;
                    end
                end
            end
        end
    end

    assign o_pyld_data       = r_pyld_data;
    assign o_pyld_data_valid = r_pyld_valid;
    assign o_pyld_sof        = r_pyld_sof;
    assign o_arq_en          = r_arq_en;
    assign o_arq_en_valid    = r_arq_valid;
    assign o_crc_err         = r_crc_err;
    assign o_crc_err_valid   = r_crc_err_valid;
    assign o_crc_val         = r_crc_val;
    assign o_sync            = w_in_sync;
    assign o_crc_err_cnt     = r_err_cnt;

endmodule
`default_nettype wire

// File: tb/tb_frame_demapper.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : tb_frame_demapper
// Description : Self-checking bench for frame_demapper against a frame-level
//               behavioural model, plus scenario-level literal expectations.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_frame_demapper;

    localparam int         ROWS     = 2;
    localparam int         COLS     = 8;
    localparam int         OH_COLS  = 2;
    localparam int         SYNC_CNT = 2;
    localparam int         LOSS_CNT = 3;
    localparam logic [7:0] POLY     = 8'h07;
    localparam int         N        = ROWS * COLS;
    localparam int         NPL      = ROWS * (COLS - OH_COLS);

    typedef logic [7:0] bq_t[$];

    logic        clk   = 1'b0;
    logic        rst_n = 1'b0;
    logic [7:0]  din   = 8'h00;
    logic        vin   = 1'b0;
    logic        fin   = 1'b0;

    logic [7:0]  o_pyld_data;
    logic        o_pyld_data_valid;
    logic        o_pyld_sof;
    logic        o_arq_en;
    logic        o_arq_en_valid;
    logic        o_crc_err;
    logic        o_crc_err_valid;
    logic [7:0]  o_crc_val;
    logic        o_sync;
    logic [15:0] o_crc_err_cnt;

    always #5 clk = ~clk;

    frame_demapper #(
        .ROWS     (ROWS),
        .COLS     (COLS),
        .OH_COLS  (OH_COLS),
        .CRC_POLY (POLY),
        .SYNC_CNT (SYNC_CNT),
        .LOSS_CNT (LOSS_CNT)
    ) dut (
        .i_clk              (clk),
        .i_rst_n            (rst_n),
        .i_frame_data       (din),
        .i_frame_data_valid (vin),
        .i_frame_data_fas   (fin),
        .o_pyld_data        (o_pyld_data),
        .o_pyld_data_valid  (o_pyld_data_valid),
        .o_pyld_sof         (o_pyld_sof),
        .o_arq_en           (o_arq_en),
        .o_arq_en_valid     (o_arq_en_valid),
        .o_crc_err          (o_crc_err),
        .o_crc_err_valid    (o_crc_err_valid),
        .o_crc_val          (o_crc_val),
        .o_sync             (o_sync),
        .o_crc_err_cnt      (o_crc_err_cnt)
    );

    int n_vec = 0;
    int n_err = 0;

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, want %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Bit-serial polynomial division over a whole message.
    function automatic logic [7:0] crc8_of(input bq_t b);
        logic [7:0] c;
        logic       fb;
        c = 8'h00;
        foreach (b[i]) begin
            for (int k = 7; k >= 0; k--) begin
                fb = c[7] ^ b[i][k];
                c  = {c[6:0], 1'b0};
                if (fb) c = c ^ POLY;
            end
        end
        return c;
    endfunction

    // Behavioural model: state 0=hunt 1=presync 2=sync, linear frame index.
    int          m_state, m_pos, m_good, m_miss;
    bit          m_prev_ok;
    bq_t         m_q;
    logic [7:0]  e_data, e_crcval;
    logic        e_pv, e_sof, e_arq, e_arqv, e_err, e_errv, e_sync;
    logic [15:0] e_cnt;

    task automatic model_reset();
        m_state = 0; m_pos = 0; m_good = 0; m_miss = 0; m_prev_ok = 0;
        m_q.delete();
        e_data = 0; e_crcval = 0; e_pv = 0; e_sof = 0; e_arq = 0; e_arqv = 0;
        e_err = 0; e_errv = 0; e_sync = 0; e_cnt = 0;
    endtask

    task automatic model_step();
        bit at0;
        if (!rst_n) begin
            model_reset();
            return;
        end
        e_pv = 0; e_sof = 0; e_arqv = 0; e_errv = 0;
        if (!vin) return;
        if (m_state == 2) begin
            if ((m_pos % COLS) >= OH_COLS) begin
                e_pv = 1; e_data = din; e_sof = (m_pos == OH_COLS);
                m_q.push_back(din);
                if (m_pos == N - 1) begin
                    e_crcval = crc8_of(m_q);
                    m_q.delete();
                    m_prev_ok = 1;
                end
            end
            if (m_pos == 1) begin
                e_arqv = 1; e_arq = din[0];
            end
            if (m_pos == COLS && m_prev_ok) begin
                e_errv = 1;
                e_err  = (din != e_crcval);
                if (e_err && e_cnt != 16'hFFFF) e_cnt = e_cnt + 16'd1;
            end
        end
        at0 = (m_pos == 0);
        case (m_state)
            0: if (fin) begin
                m_pos = 1; m_good = 1; m_miss = 0;
                m_state = (SYNC_CNT == 1) ? 2 : 1;
            end
            1: begin
                if (at0 && fin) begin
                    m_good++;
                    if (m_good >= SYNC_CNT) begin m_state = 2; m_miss = 0; end
                end else if (at0 || fin) begin
                    m_state = 0;
                end
                m_pos = (m_pos + 1) % N;
            end
            default: begin
                if (at0 && fin) m_miss = 0;
                else if (at0 || fin) begin
                    m_miss++;
                    if (m_miss >= LOSS_CNT) begin
                        m_state = 0; m_q.delete(); m_prev_ok = 0;
                    end
                end
                m_pos = (m_pos + 1) % N;
            end
        endcase
        e_sync = (m_state == 2);
    endtask

    // Observed activity, used by the scenario-level checks.
    int  n_pv = 0, n_sof = 0, n_arq = 0, n_crcs = 0;
    bq_t cap_q;

    always @(posedge clk) begin
        model_step();
        #1;
        chk("sync", o_sync, e_sync);
        chk("pyld_valid", o_pyld_data_valid, e_pv);
        chk("pyld_sof", o_pyld_sof, e_sof);
        chk("arq_valid", o_arq_en_valid, e_arqv);
        chk("arq_en", o_arq_en, e_arq);
        chk("crc_err_valid", o_crc_err_valid, e_errv);
        chk("crc_err", o_crc_err, e_err);
        chk("crc_val", o_crc_val, e_crcval);
        chk("crc_err_cnt", o_crc_err_cnt, e_cnt);
        if (e_pv) chk("pyld_data", o_pyld_data, e_data);
        if (o_pyld_data_valid) begin
            n_pv++;
            cap_q.push_back(o_pyld_data);
        end
        if (o_pyld_sof) n_sof++;
        if (o_arq_en_valid) n_arq++;
        if (o_crc_err_valid) n_crcs++;
    end

    // Stimulus: inputs change on the falling edge only.
    logic [7:0] tx_pl [NPL];
    logic [7:0] tx_prev_crc = 8'h00;
    logic [7:0] tx_arq      = 8'h01;

    task automatic beat(input logic v, input logic f, input logic [7:0] d);
        @(negedge clk);
        vin = v; fin = f; din = d;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) beat(1'b0, 1'($urandom), 8'($urandom));
    endtask

    task automatic fill_payload(input bit rnd);
        for (int k = 0; k < NPL; k++) tx_pl[k] = rnd ? 8'($urandom) : 8'(k);
    endtask

    task automatic send_frame(input bit fas_on, input int spur_pos, input int corrupt_k,
                              input int gap_pct, input int nbeats);
        bq_t clean;
        for (int p = 0; p < nbeats; p++) begin
            int         r, c, k;
            logic [7:0] d;
            logic       f;
            r = p / COLS;
            c = p % COLS;
            while (int'($urandom_range(99)) < gap_pct) beat(1'b0, 1'($urandom), 8'($urandom));
            f = (p == spur_pos) || (p == 0 && fas_on);
            if (p == 0)          d = 8'hF6;
            else if (p == 1)     d = tx_arq;
            else if (p == COLS)  d = tx_prev_crc;
            else if (c < OH_COLS) d = 8'($urandom);
            else begin
                k = r * (COLS - OH_COLS) + c - OH_COLS;
                d = tx_pl[k] ^ ((k == corrupt_k) ? 8'h5A : 8'h00);
            end
            beat(1'b1, f, d);
        end
        for (int k = 0; k < NPL; k++) clean.push_back(tx_pl[k]);
        tx_prev_crc = crc8_of(clean);
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_pyld_data"}, o_pyld_data, 16'h0);
        chk({tag, "_pyld_valid"}, o_pyld_data_valid, 16'h0);
        chk({tag, "_sof"}, o_pyld_sof, 16'h0);
        chk({tag, "_arq"}, {o_arq_en, o_arq_en_valid}, 16'h0);
        chk({tag, "_crc_err"}, {o_crc_err, o_crc_err_valid}, 16'h0);
        chk({tag, "_crc_val"}, o_crc_val, 16'h0);
        chk({tag, "_sync"}, o_sync, 16'h0);
        chk({tag, "_cnt"}, o_crc_err_cnt, 16'h0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0; vin = 1'b0; fin = 1'b0;
        repeat (3) @(negedge clk);
        chk_zero("reset");
        rst_n = 1'b1;
        tx_prev_crc = 8'h00;
        tx_arq = 8'h01;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout, want completion");
        $fatal(1);
    end

    initial begin
        bq_t t;
        bq_t qa;
        int  pv0, sof0, arq0, crcs0;
        logic [7:0] crc_a;
        int  crcs_a;

        // Pin the model CRC: single byte 01 and the standard "123456789" check value.
        t = '{8'h01};
        chk("model_crc_01", crc8_of(t), 16'h07);
        t = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39};
        chk("model_crc_check", crc8_of(t), 16'hF4);

        // Clean stream, payload 00..0B, ARQ byte 01.
        do_reset();
        fill_payload(1'b0);
        send_frame(1, -1, -1, 0, N);
        idle(2);
        chk("clean_sync_after_f1", o_sync, 16'h0);
        pv0 = n_pv; sof0 = n_sof; arq0 = n_arq; crcs0 = n_crcs;
        for (int f = 0; f < 3; f++) send_frame(1, -1, -1, 0, N);
        idle(2);
        chk("clean_sync", o_sync, 16'h1);
        chk("clean_pyld_beats", 16'(n_pv - pv0), 16'd36);
        chk("clean_sof_count", 16'(n_sof - sof0), 16'd3);
        chk("clean_arq_count", 16'(n_arq - arq0), 16'd3);
        chk("clean_arq_en", o_arq_en, 16'h1);
        chk("clean_crc_strobes", 16'(n_crcs - crcs0), 16'd2);
        chk("clean_crc_err", o_crc_err, 16'h0);
        chk("clean_err_cnt", o_crc_err_cnt, 16'h0);
        t.delete();
        for (int k = 0; k < NPL; k++) t.push_back(8'(k));
        chk("clean_crc_val", o_crc_val, 16'(crc8_of(t)));

        // One corrupted payload byte in frame 3 is flagged during frame 4.
        do_reset();
        fill_payload(1'b0);
        send_frame(1, -1, -1, 0, N);
        send_frame(1, -1, -1, 0, N);
        send_frame(1, -1, 5, 0, N);
        idle(2);
        chk("corrupt_cnt_before", o_crc_err_cnt, 16'd0);
        send_frame(1, -1, -1, 0, N);
        idle(2);
        chk("corrupt_cnt_after", o_crc_err_cnt, 16'd1);
        chk("corrupt_err_held", o_crc_err, 16'h1);

        // Stray FAS at row 1 col 3 during PRESYNC.
        do_reset();
        fill_payload(1'b1);
        pv0 = n_pv;
        send_frame(1, 1 * COLS + 3, -1, 0, N);
        send_frame(1, -1, -1, 0, N);
        idle(2);
        chk("spur_sync", o_sync, 16'h0);
        chk("spur_no_pyld", 16'(n_pv - pv0), 16'd0);
        send_frame(1, -1, -1, 0, N);
        send_frame(1, -1, -1, 0, N);
        idle(2);
        chk("spur_resync", o_sync, 16'h1);

        // Loss hysteresis: two missed FAS tolerated, three drop SYNC.
        for (int f = 0; f < 2; f++) begin
            tx_arq = 8'($urandom);
            fill_payload(1'b1);
            send_frame(0, -1, -1, 0, N);
            idle(1);
            chk("loss2_sync_held", o_sync, 16'h1);
        end
        send_frame(1, -1, -1, 0, N);
        idle(1);
        chk("loss_restore_sync", o_sync, 16'h1);
        pv0 = n_pv;
        for (int f = 0; f < 2; f++) begin
            tx_arq = 8'($urandom);
            send_frame(0, -1, -1, 0, N);
        end
        idle(1);
        chk("loss3_sync_before", o_sync, 16'h1);
        chk("loss3_pyld_before", 16'(n_pv - pv0), 16'd24);
        pv0 = n_pv;
        send_frame(0, -1, -1, 0, N);
        idle(2);
        chk("loss3_sync_dropped", o_sync, 16'h0);
        chk("loss3_pyld_stopped", 16'(n_pv - pv0), 16'd0);

        // Valid gaps must not change the delivered payload or CRC results.
        do_reset();
        fill_payload(1'b1);
        cap_q.delete();
        crcs0 = n_crcs;
        for (int f = 0; f < 3; f++) send_frame(1, -1, -1, 0, N);
        idle(2);
        qa = cap_q;
        crc_a = o_crc_val;
        crcs_a = n_crcs - crcs0;
        do_reset();
        cap_q.delete();
        crcs0 = n_crcs;
        for (int f = 0; f < 3; f++) send_frame(1, -1, -1, 50, N);
        idle(2);
        chk("gap_ref_len", 16'(qa.size()), 16'd24);
        chk("gap_len", 16'(cap_q.size()), 16'(qa.size()));
        for (int i = 0; i < qa.size() && i < cap_q.size(); i++) begin
            if (cap_q[i] !== qa[i]) chk($sformatf("gap_byte%0d", i), cap_q[i], qa[i]);
        end
        chk("gap_crc_val", o_crc_val, 16'(crc_a));
        chk("gap_crc_strobes", 16'(n_crcs - crcs0), 16'(crcs_a));
        chk("gap_crc_err", o_crc_err, 16'h0);

        // Reset mid-payload while in SYNC, then check the CRC-compare holdoff.
        do_reset();
        fill_payload(1'b1);
        for (int f = 0; f < 3; f++) send_frame(1, -1, -1, 0, N);
        send_frame(1, -1, -1, 0, 5);
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        vin = 1'b0;
        #1;
        chk_zero("midrst");
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        tx_prev_crc = 8'h00;
        crcs0 = n_crcs;
        send_frame(1, -1, -1, 0, N);
        send_frame(1, -1, -1, 0, N);
        idle(2);
        chk("midrst_no_early_crc", 16'(n_crcs - crcs0), 16'd0);
        send_frame(1, -1, -1, 0, N);
        idle(2);
        chk("midrst_first_crc", 16'(n_crcs - crcs0), 16'd1);
        chk("midrst_crc_err", o_crc_err, 16'h0);

        idle(2);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
